// File: rtl/riscv_pkg.sv
// Shared definitions for the core's front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0), shown to decode when no
//                   instruction is available
//   fetch_entry_t : one fetched word together with the address it came from
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and decode.
// Circular buffer of fetch_entry_t with registered head.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : synchronous flush (has priority over push/pop)
//   push        : write push_data (accepted when not full, or full with pop)
//   pop         : drop the head entry (ignored when empty)
//   head        : oldest entry
//   count       : number of stored entries
//   full, empty : occupancy flags
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Entries are reset so the head reads as pc 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{instr: NOP_INSTR, pc: '0};
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, keeps at most one request in
// flight to instruction memory, buffers returned words and presents one
// {instr, pc, pc_plus_4} bundle per cycle to decode. Redirects from execute
// flush the buffer and discard a wrong-path response still in flight.
//   clk, reset                      : clock, asynchronous active-high reset
//   imem_req_valid/ready, imem_addr : request channel to instruction memory
//   imem_resp_valid, imem_resp_data : in-order responses
//   redirect, redirect_target       : taken branch/jump from execute
//   id_stall                        : decode cannot accept this cycle
//   id_valid, id_instr, id_pc,
//   id_pc_plus_4                    : bundle presented to decode
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus_4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ALMOST_FULL = CW'(DEPTH - 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          drop;
  logic          outstanding_next;
  logic          resp_fire;
  logic          push;
  logic          pop;
  logic          accept;
  logic          space_ok;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          unused_target_lsb;

  assign unused_target_lsb = ^redirect_target[1:0];

  // A redirect cycle ignores any response or pop; the flush wins.
  assign resp_fire        = imem_resp_valid && outstanding && !redirect;
  assign push             = resp_fire && !drop;
  assign pop              = id_valid && !id_stall && !redirect;
  assign outstanding_next = outstanding && !imem_resp_valid;

  // Only ask for a word if the buffer will still have a free slot for it
  // after this cycle's push/pop settle. Counting a same-cycle pop lets a
  // one-cycle memory stream at full rate; counting a same-cycle push keeps a
  // stalled decode from overrunning the buffer.
  always_comb begin
    space_ok = !full;
    if (push && !pop) begin
      space_ok = (count < ALMOST_FULL);
    end else if (pop && !push) begin
      space_ok = 1'b1;
    end
  end

  assign imem_req_valid = !reset && !redirect && !outstanding_next && space_ok;
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_addr      = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= {redirect_target[31:2], 2'b00};
      // A wrong-path response still on its way must be swallowed later.
      drop        <= outstanding && !imem_resp_valid;
      outstanding <= outstanding && !imem_resp_valid;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      outstanding <= accept ? 1'b1 : outstanding_next;
      if (resp_fire && drop) begin
        drop <= 1'b0;
      end
    end
  end

  assign push_data = '{instr: imem_resp_data, pc: req_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign id_valid     = !empty;
  assign id_instr     = id_valid ? head.instr : NOP_INSTR;
  assign id_pc        = head.pc;
  assign id_pc_plus_4 = head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory with variable latency
// and an expected-program-order model of the delivered stream.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus_4;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus_4    (id_pc_plus_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  logic        ready_ctl = 1'b1;
  logic [31:0] exp_pc;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        s_req_valid, s_valid, s_acc;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle; called at a falling edge, returns at the next one.
  task automatic step(input logic stall, input logic redir, input logic [31:0] tgt);
    logic        acc;
    logic        popd;
    logic        resp;
    logic [31:0] a_addr;
    int          rem;
    id_stall        = stall;
    redirect        = redir;
    redirect_target = tgt;
    imem_req_ready  = ready_ctl;
    resp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? word_of(pend[0].addr) : $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_addr      = imem_addr;
    s_valid     = id_valid;
    s_pc        = id_pc;
    if (!id_valid) check("nop_when_idle", id_instr, NOP_INSTR);
    else check("pc_plus_4", id_pc_plus_4, id_pc + 32'd4);
    if (prev_hold && !redir) begin
      check("req_held", 32'(imem_req_valid), 32'd1);
      check("addr_held", imem_addr, prev_addr);
    end
    if (imem_req_valid) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
    acc   = imem_req_valid && imem_req_ready;
    s_acc = acc;
    popd  = id_valid && !stall && !redir;
    if (popd) begin
      check("stream_pc", id_pc, exp_pc);
      check("stream_instr", id_instr, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (acc) begin
      rem = pend.size() - (resp ? 1 : 0);
      check("one_outstanding", 32'(rem), 32'd0);
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    a_addr    = imem_addr;
    prev_hold = imem_req_valid && !imem_req_ready;
    prev_addr = imem_addr;
    @(posedge clk);
    if (resp) void'(pend.pop_front());
    if (acc) pend.push_back('{addr: a_addr, due: cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_values(string pfx);
    check({pfx, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({pfx, "_addr"}, imem_addr, RST_PC);
    check({pfx, "_id_valid"}, 32'(id_valid), 32'd0);
    check({pfx, "_instr"}, id_instr, NOP_INSTR);
    check({pfx, "_pc"}, id_pc, 32'd0);
    check({pfx, "_pc4"}, id_pc_plus_4, 32'd4);
  endtask

  task automatic release_reset();
    reset     = 1'b0;
    pend.delete();
    cyc       = 0;
    exp_pc    = RST_PC;
    prev_hold = 1'b0;
  endtask

  initial begin
    logic found;
    int   p0;
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect = 1'b0; redirect_target = '0; id_stall = 1'b0;
    exp_pc = RST_PC;
    #3;
    check_reset_values("rst");
    repeat (2) @(negedge clk);
    release_reset();

    // Zero-wait streaming from reset.
    ready_ctl = 1'b1; lat = 1;
    step(0, 0, 0);
    check("c0_req_valid", 32'(s_req_valid), 32'd1);
    check("c0_addr", s_addr, RST_PC);
    check("c0_id_valid", 32'(s_valid), 32'd0);
    step(0, 0, 0);
    check("c1_id_valid", 32'(s_valid), 32'd0);
    step(0, 0, 0);
    check("c2_id_valid", 32'(s_valid), 32'd1);
    check("c2_pc", s_pc, 32'd0);
    step(0, 0, 0);
    check("c3_pc", s_pc, 32'd4);

    // Decode stall at pc 8.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      check("stall_pc", s_pc, 32'd8);
      check("stall_valid", 32'(s_valid), 32'd1);
    end
    check("stall_no_req", 32'(s_req_valid), 32'd0);
    step(0, 0, 0);
    check("release_pc", s_pc, 32'd8);
    step(0, 0, 0);
    check("resume_pc", s_pc, 32'd12);
    repeat (3) step(0, 0, 0);

    // Misaligned redirect target.
    step(0, 1, 32'h0000_0203);
    step(0, 0, 0);
    check("redir_bubble", 32'(s_valid), 32'd0);
    check("redir_req_valid", 32'(s_req_valid), 32'd1);
    check("redir_addr", s_addr, 32'h0000_0200);
    step(0, 0, 0);
    step(0, 0, 0);
    check("redir_first_valid", 32'(s_valid), 32'd1);
    check("redir_first_pc", s_pc, 32'h0000_0200);

    // Redirect while the 0x10 response is in flight (3-cycle memory).
    lat = 3;
    step(0, 1, 32'h0000_0010);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, 0, 0);
      if (s_acc && s_addr == 32'h0000_0010) found = 1'b1;
    end
    check("acc_0x10_seen", 32'(found), 32'd1);
    step(0, 1, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      step(0, 0, 0);
      if (s_valid) found = 1'b1;
    end
    check("drop_valid_seen", 32'(found), 32'd1);
    check("drop_first_pc", s_pc, 32'h0000_0100);

    // Memory not ready for 4 cycles.
    lat = 1;
    repeat (6) step(0, 0, 0);
    ready_ctl = 1'b0;
    step(0, 0, 0);
    p0 = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("notready_drained", 32'(s_valid), 32'd0);
    check("notready_req_valid", 32'(s_req_valid), 32'd1);
    ready_ctl = 1'b1;
    repeat (6) step(0, 0, 0);

    // Asynchronous reset with a response pending.
    lat = 3;
    for (int i = 0; i < 10 && pend.size() == 0; i++) step(0, 0, 0);
    check("pend_before_reset", 32'(pend.size() != 0), 32'd1);
    #2;
    reset = 1'b1;
    imem_resp_valid = 1'b0;
    #1;
    check_reset_values("arst");
    pend.delete();
    repeat (2) @(negedge clk);
    release_reset();
    lat = 1;
    step(0, 0, 0);
    check("rst2_req_valid", 32'(s_req_valid), 32'd1);
    check("rst2_addr", s_addr, RST_PC);
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst2_valid", 32'(s_valid), 32'd1);
    check("rst2_pc", s_pc, RST_PC);

    // Random traffic.
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 3);
      ready_ctl = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom & 32'h0000_0fff);
    end
    check("random_progress", 32'((pops - p0) > 40), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 5-stage core; sits directly upstream of decode and the execute datapath. Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with fixed-order responses. Buffers returned words in a small FIFO and presents one `{instr, pc, pc_plus_4}` bundle per cycle to decode. Honours decode stalls and execute redirects (taken branch/jump), discarding wrong-path data.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction-buffer entries (power of two, ≥2)
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_addr`  out  32  word-aligned fetch address
- `imem_resp_valid`  in  1  response valid (≥1 cycle after acceptance, in order)
- `imem_resp_data`  in  32  instruction word
- `redirect`  in  1  execute resolved a taken branch/jump (pc_src)
- `redirect_target`  in  32  new PC (pc_target); bits [1:0] ignored
- `id_stall`  in  1  decode cannot accept this cycle
- `id_valid`  out  1  bundle at head is valid
- `id_instr`  out  32  instruction, NOP 32'h0000_0013 when `!id_valid`
- `id_pc`  out  32  address of `id_instr`
- `id_pc_plus_4`  out  32  `id_pc + 4`

## Operation
- `fetch_pc` register: next address to request; advances by 4 on each accepted request, wraps modulo 2^32.
- `outstanding` (1 bit): at most one accepted, unanswered request.
- Issue rule: `imem_req_valid = !redirect_pending_issue && (count + outstanding_next < DEPTH)`, where `outstanding_next` counts a response arriving this cycle as retired; allows back-to-back requests with a 1-cycle memory.
- Request held with stable `imem_addr` until accepted, except a redirect may replace it (memory must tolerate withdrawal).
- Response: if `drop` clear, push `{imem_resp_data, addr}` into FIFO; if `drop` set, discard it and clear `drop`.
- Pop: `id_valid && !id_stall`. Push and pop same cycle allowed at full or empty.
- Redirect (highest priority): at clock edge FIFO cleared, `fetch_pc <= {redirect_target[31:2],2'b00}`, `drop <= outstanding && !resp_this_cycle`; any response or pop in the same cycle is ignored; no request issued that cycle.
- Outputs driven from FIFO head registers; `id_pc_plus_4` computed from head `pc`.
- Reset values: `imem_req_valid`=0 (during reset), `imem_addr`=`RESET_PC`, `id_valid`=0, `id_instr`=32'h0000_0013, `id_pc`=0, `id_pc_plus_4`=4, `outstanding`=0, `drop`=0, FIFO empty. Reset mid-transaction abandons outstanding responses; memory is reset together.

## Timing
- Cycle 0 = first cycle after `reset` deasserts: request for `RESET_PC` issued.
- Zero-wait memory (ready=1, response next cycle): first `id_valid` at cycle 2; steady-state 1 instr/cycle.
- Redirect in cycle t: new-target request in t+1; `id_valid` with target instruction earliest t+3; `id_valid`=0 in t+1.
- `id_stall` held: head stable; FIFO fills to `DEPTH`, then requests stop; release resumes delivery next cycle with no lost or duplicated words.
- Redirect during `id_stall`: flush still occurs; stall does not block redirect.

## Structure
- `riscv_pkg`: `XLEN`, `NOP_INSTR` (32'h0000_0013), `fetch_entry_t` struct `{instr, pc}`.
- Sub-module `fetch_fifo` (parameter `DEPTH`, element `fetch_entry_t`, push/pop/clear, count, full/empty); top holds PC, outstanding/drop tracking, output mapping.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr-tagged words: `id_pc` = 0,4,8,12 on consecutive cycles from cycle 2; `id_pc_plus_4` = `id_pc`+4.
- `id_stall` high for 5 cycles at id_pc=8: outputs frozen at 8, `imem_req_valid` drops once 2 entries + 0 outstanding; release → 8,12,16,… without gap or repeat.
- Redirect to 0x100 while response for 0x10 in flight (3-cycle latency): 0x10 word discarded, next `id_valid` shows `id_pc`=0x100.
- Redirect with target 0x203: fetch at 0x200.
- `imem_req_ready` low 4 cycles: `imem_addr` stable, `id_valid` goes 0 after FIFO drains, no duplicate PCs.
- Reset asserted mid-stream with response pending: outputs return to reset values asynchronously; after release fetching restarts at `RESET_PC`.
